// File: rtl/corep_pkg.sv
// Shared core types: PC/history widths and the gbpt update payload.
package corep;

   localparam int unsigned PC38_W              = 38;
   localparam int unsigned GH_W                = 12;
   localparam int unsigned GBPT_UPDQ_DEPTH     = 8;
   localparam int unsigned GBPT_UPDQ_ENQ_LANES = 2;

   typedef logic [PC38_W-1:0] PC38_t;
   typedef logic [GH_W-1:0]   GH_t;

   typedef struct packed {
      PC38_t pc38;
      GH_t   gh;
      logic  taken;
   } gbpt_update_t;

endpackage

// File: rtl/gbpt_update_queue.sv
// Transmit queue for gbpt updates: absorbs 2-wide branch resolutions, drains one per cycle in order.
// Optional same-cycle bypass on an empty queue: define GBPT_UPDQ_BYPASS_EN.
module gbpt_update_queue
   import corep::*;
#(
   parameter int unsigned DEPTH = GBPT_UPDQ_DEPTH
) (
   input  logic                                 CLK,
   input  logic                                 nRST,
   input  logic [GBPT_UPDQ_ENQ_LANES-1:0]       enq_valid_by_lane,
   input  PC38_t [GBPT_UPDQ_ENQ_LANES-1:0]      enq_pc38_by_lane,
   input  GH_t [GBPT_UPDQ_ENQ_LANES-1:0]        enq_gh_by_lane,
   input  logic [GBPT_UPDQ_ENQ_LANES-1:0]       enq_taken_by_lane,
   output logic                                 enq_ready,
   output logic                                 update_valid,
   output PC38_t                                update_pc38,
   output GH_t                                  update_gh,
   output logic                                 update_taken
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   gbpt_update_t       mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;

   logic [1:0]         acc;
   logic [CNT_W-1:0]   n_enq;
   logic [CNT_W-1:0]   wr_n;
   logic [CNT_W-1:0]   count_next;
   logic               deq;
   logic               out_valid;
   gbpt_update_t       lane0;
   gbpt_update_t       lane1;
   gbpt_update_t       first;
   gbpt_update_t       wr0;
   gbpt_update_t       head_ent;

   // Accept, compact and size the enqueue; pick the entry presented to gbpt.
   always_comb begin
      lane0      = {enq_pc38_by_lane[0], enq_gh_by_lane[0], enq_taken_by_lane[0]};
      lane1      = {enq_pc38_by_lane[1], enq_gh_by_lane[1], enq_taken_by_lane[1]};
      acc        = enq_ready ? enq_valid_by_lane : 2'b00;
      n_enq      = CNT_W'(acc[0]) + CNT_W'(acc[1]);
      first      = acc[0] ? lane0 : lane1;
      deq        = (count != '0);
`ifdef GBPT_UPDQ_BYPASS_EN
      // Empty queue: the oldest accepted lane goes straight to the port and skips storage.
      if ((count == '0) && (acc != 2'b00)) begin
         wr_n      = n_enq - CNT_W'(1);
         wr0       = lane1;
         head_ent  = first;
         out_valid = 1'b1;
      end else begin
         wr_n      = n_enq;
         wr0       = first;
         head_ent  = mem[head];
         out_valid = deq;
      end
`else
      wr_n       = n_enq;
      wr0        = first;
      head_ent   = mem[head];
      out_valid  = deq;
`endif
      count_next = count + wr_n - CNT_W'(deq);
   end

   always_comb begin
      update_valid = out_valid;
      update_pc38  = out_valid ? head_ent.pc38  : '0;
      update_gh    = out_valid ? head_ent.gh    : '0;
      update_taken = out_valid ? head_ent.taken : 1'b0;
   end

   // Pointer/occupancy state; enq_ready is precomputed from next occupancy.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         enq_ready <= 1'b1;
      end else begin
         head      <= head + PTR_W'(deq);
         tail      <= tail + PTR_W'(wr_n);
         count     <= count_next;
         enq_ready <= (count_next <= CNT_W'(DEPTH - 2));
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge CLK) begin
      if (wr_n != '0) mem[tail] <= wr0;
      if (wr_n == CNT_W'(2)) mem[tail + PTR_W'(1)] <= lane1;
   end

endmodule
